spi_slave_frame: RTL and testbench
==================================

Name: spi_slave_frame

Overview:
- Parametrised successor to the MCU-facing SPI slave inside main: receives and transmits fixed-length frames from the MCU over MCU_SPI_* pins.
- Generalised in frame length, SPI mode (CPOL/CPHA) and bit order; adds an rx handshake, overrun and short-frame detection, and back-to-back frames.
- All logic runs on CLK; SCK/MOSI/NSS are oversampled, never used as clocks.
- Sits between the MCU pins and the register/command decoder.

Parameters:
FRAME_BITS, 64, bits per frame; legal range 8..256.
CPOL, 0, SCK idle level.
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
MSB_FIRST, 1, 1 = bit FRAME_BITS-1 shifted first; 0 = bit 0 first.

Ports:
CLK  in  1  system clock; must be >= 4x SCK frequency.
RST  in  1  synchronous, active-high reset.
MCU_SPI_SCK  in  1  SPI clock, asynchronous.
MCU_SPI_MOSI  in  1  SPI data in, asynchronous.
MCU_SPI_NSS  in  1  chip select, active low, asynchronous.
MCU_SPI_MISO  out  1  SPI data out.
miso_oe  out  1  MISO output enable; 1 while NSS is synchronised low.
tx_data  in  FRAME_BITS  reply word; sampled at frame start.
rx_data  out  FRAME_BITS  last accepted frame.
rx_valid  out  1  rx_data valid; held until consumed.
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
rx_overrun  out  1  one-CLK pulse when a completed frame is dropped.
frame_err  out  1  one-CLK pulse when NSS rises mid-frame.
rx_crc_err  out  1  CRC mismatch flag (see Optional Feature).
busy  out  1  high while a frame is in progress.

Behaviour:
- Synchronisation:
  - SCK, MOSI and NSS each pass through a 2-FF synchroniser.
  - SCK gets a third register for edge detection.
  - Pin-to-internal latency: 2 CLK, plus 1 CLK for edge detection.
- Edges:
  - lead = rising if CPOL=0, falling if CPOL=1; trail is the opposite edge.
  - sample = lead if CPHA=0, else trail; shift = the other edge.
  - SCK edges are ignored while synchronised NSS is high.
- Reset: every output is 0 (MISO=0, miso_oe=0, rx_data=0, rx_valid=0, busy=0); bit_cnt=0; armed=0.
- armed: set only while synchronised NSS is high. A frame cannot start until armed=1, so NSS already low at reset release is ignored until it goes high.
- States:
  - IDLE: on NSS fall with armed=1, load tx shift register from tx_data, set bit_cnt=0, busy=1, go to ACTIVE.
    - CPHA=0: MISO shows the first bit in the same cycle as the load.
  - ACTIVE, on a sample edge: shift the synchronised MOSI into the rx shift register and increment bit_cnt.
  - ACTIVE, on a shift edge: advance the tx register and update MISO. For CPHA=1 the first shift edge presents the first bit.
  - Frame complete: when bit_cnt reaches FRAME_BITS after a sample edge:
    - if rx_valid=0 or rx_ready=1 that cycle: rx_data <= shift register and rx_valid=1 on the next CLK;
    - otherwise: rx_data is kept, rx_overrun pulses for 1 CLK, and the new frame is dropped.
    - Then bit_cnt <= 0 and tx is reloaded from tx_data, so back-to-back frames continue while NSS stays low.
  - NSS rise in ACTIVE:
    - bit_cnt != 0: frame_err pulses for 1 CLK and partial data is discarded;
    - bit_cnt == 0: clean end.
    - Either way go to IDLE with busy=0.
- Handshake: rx_valid clears on the CLK after rx_valid & rx_ready. Accept and complete in the same cycle gives new data and rx_valid stays 1.
- Bit order: MSB_FIRST selects left versus right shift for both rx and tx.
- RST asserted mid-frame aborts the frame with no frame_err and restarts from the reset state.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_CRC8_EN.
- Defined:
  - A serial CRC-8 (poly 0x07, init 0x00, MSB-in) runs over the first FRAME_BITS-8 received bits.
  - The last 8 bits are compared against it at frame completion.
  - On mismatch: rx_crc_err=1 alongside rx_valid, and it clears with rx_valid. The data is still delivered.
  - The CRC restarts at each frame start.
- Undefined: no CRC logic is built; rx_crc_err is tied 0.

Test Plan:
- Mode 0, MSB first, NSS low, 64 SCK cycles with MOSI = 64'h0123_4567_89AB_CDEF, tx_data = 64'hDEAD_BEEF_CAFE_F00D, rx_ready=1 -> rx_valid pulses once with rx_data=64'h0123_4567_89AB_CDEF; MISO bits captured on rising SCK = 64'hDEAD_BEEF_CAFE_F00D.
- Modes 1, 2, 3 and MSB_FIRST=0 with FRAME_BITS=16, MOSI 16'hA55A -> rx_data = 16'hA55A in every mode; MISO matches the mode's sample edge.
- NSS raised after 20 of 64 bits -> frame_err pulses exactly 1 CLK, rx_valid stays 0; the next full frame is received correctly.
- rx_ready=0, two back-to-back frames 64'h1 then 64'h2 without NSS rising -> rx_data=64'h1, rx_overrun pulses once; setting rx_ready=1 clears rx_valid one CLK later.
- RST held high after 10 bits, NSS still low -> no frame is accepted until NSS goes high then low; a full frame 64'hFFFF_0000_FFFF_0000 is then received.
- With SPI_SLAVE_FRAME_CRC8_EN and FRAME_BITS=16: payload 8'h01 with CRC byte 8'h07 -> rx_crc_err=0; CRC byte 8'h08 -> rx_crc_err=1 with rx_data=16'h0108.

Source files
------------

// File: rtl/spi_slave_frame.sv
// spi_slave_frame: MCU-facing SPI slave that moves fixed-length frames.
//
// The SPI pins are oversampled on CLK. No pin is used as a clock. Frames of
// FRAME_BITS bits are shifted in on MOSI and out on MISO. The SPI mode
// (CPOL/CPHA) and the bit order (MSB_FIRST) are parameters. While NSS stays
// low, frames follow each other back to back.
//
// Optional feature: define SPI_SLAVE_FRAME_CRC8_EN to build a CRC-8 check
// (poly 0x07, init 0x00, MSB-in). The check runs over the first FRAME_BITS-8
// bits of each frame and compares the result against the last 8 bits. When
// the macro is undefined, rx_crc_err is tied to 0.
//
// Ports:
//   CLK, RST        system clock, synchronous active-high reset
//   MCU_SPI_SCK     SPI clock (asynchronous, oversampled)
//   MCU_SPI_MOSI    SPI data in (asynchronous)
//   MCU_SPI_NSS     chip select, active low (asynchronous)
//   MCU_SPI_MISO    SPI data out
//   miso_oe         MISO output enable, high while synchronised NSS is low
//   tx_data         reply word, captured at each frame start
//   rx_data         last accepted frame
//   rx_valid        rx_data valid, held until rx_valid & rx_ready
//   rx_ready        consumer ready
//   rx_overrun      1-CLK pulse when a completed frame is dropped
//   frame_err       1-CLK pulse when NSS rises mid-frame
//   rx_crc_err      CRC mismatch flag for the delivered frame
//   busy            high while a frame is in progress
module spi_slave_frame #(
  parameter int unsigned FRAME_BITS = 64,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MCU_SPI_SCK,
  input  logic                  MCU_SPI_MOSI,
  input  logic                  MCU_SPI_NSS,
  output logic                  MCU_SPI_MISO,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  frame_err,
  output logic                  rx_crc_err,
  output logic                  busy
);

  localparam int unsigned     CntW    = $clog2(FRAME_BITS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_BITS - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Synchronisers
  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic       nss_s1_q, nss_s2_q;
  // Marks the NSS synchroniser as flushed of its reset value.
  logic [1:0] sync_vld_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sck_s1_q   <= CPOL;
      sck_s2_q   <= CPOL;
      sck_s3_q   <= CPOL;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      nss_s1_q   <= 1'b1;
      nss_s2_q   <= 1'b1;
      sync_vld_q <= 2'b00;
    end else begin
      sck_s1_q   <= MCU_SPI_SCK;
      sck_s2_q   <= sck_s1_q;
      sck_s3_q   <= sck_s2_q;
      mosi_s1_q  <= MCU_SPI_MOSI;
      mosi_s2_q  <= mosi_s1_q;
      nss_s1_q   <= MCU_SPI_NSS;
      nss_s2_q   <= nss_s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // Edge decode
  logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;

  assign sck_rise    = sck_s2_q & ~sck_s3_q;
  assign sck_fall    = ~sck_s2_q & sck_s3_q;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = (CPHA ? trail_edge : lead_edge) & ~nss_s2_q;
  assign shift_edge  = (CPHA ? lead_edge : trail_edge) & ~nss_s2_q;

  // State
  state_e                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic                    miso_q, miso_d;
  logic                    miso_oe_q, miso_oe_d;
  logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_overrun_q, rx_overrun_d;
  logic                    frame_err_q, frame_err_d;
  logic                    busy_q, busy_d;

  logic                    accept, frame_start, rx_shift, frame_done, deliver;
  logic [FRAME_BITS-1:0]   rx_shifted;

  function automatic logic tx_first(input logic [FRAME_BITS-1:0] v);
    return MSB_FIRST ? v[FRAME_BITS-1] : v[0];
  endfunction

  function automatic logic [FRAME_BITS-1:0] tx_adv(input logic [FRAME_BITS-1:0] v);
    return MSB_FIRST ? {v[FRAME_BITS-2:0], 1'b0} : {1'b0, v[FRAME_BITS-1:1]};
  endfunction

  assign rx_shifted  = MSB_FIRST ? {rx_sr_q[FRAME_BITS-2:0], mosi_s2_q}
                                 : {mosi_s2_q, rx_sr_q[FRAME_BITS-1:1]};
  assign accept      = rx_valid_q & rx_ready;
  assign frame_start = (state_q == StIdle) & armed_q & ~nss_s2_q;
  assign rx_shift    = (state_q == StActive) & sample_edge;
  assign frame_done  = rx_shift & (bit_cnt_q == LastCnt);
  // A finished frame is taken only if the output slot is free or is being freed now.
  assign deliver     = frame_done & (~rx_valid_q | rx_ready);

  always_comb begin
    state_d      = state_q;
    // Arming needs a genuine high NSS, not the reset value of the synchroniser.
    armed_d      = armed_q | (nss_s2_q & sync_vld_q[1]);
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    miso_d       = miso_q;
    miso_oe_d    = ~nss_s2_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;
    frame_err_d  = 1'b0;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d   = StActive;
          bit_cnt_d = '0;
          if (CPHA) begin
            // The first shift edge presents the first bit.
            tx_sr_d = tx_data;
            miso_d  = 1'b0;
          end else begin
            miso_d  = tx_first(tx_data);
            tx_sr_d = tx_adv(tx_data);
          end
        end
      end
      StActive: begin
        if (nss_s2_q) begin
          state_d     = StIdle;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          miso_d      = 1'b0;
        end else if (rx_shift) begin
          rx_sr_d = rx_shifted;
          if (frame_done) begin
            bit_cnt_d = '0;
            // Reload whole word: the shift edge that follows presents its first bit.
            tx_sr_d   = tx_data;
            if (deliver) begin
              rx_data_d  = rx_shifted;
              rx_valid_d = 1'b1;
            end else begin
              rx_overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (shift_edge) begin
          miso_d  = tx_first(tx_sr_q);
          tx_sr_d = tx_adv(tx_sr_q);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StActive);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      tx_sr_q      <= tx_sr_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef SPI_SLAVE_FRAME_CRC8_EN
  localparam logic [CntW-1:0] CrcBits = CntW'(FRAME_BITS - 8);

  logic [7:0] crc_q, crc_d;
  logic [7:0] tail_q, tail_d;
  logic       crc_err_q, crc_err_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    crc_d     = crc_q;
    tail_d    = tail_q;
    crc_err_d = crc_err_q;
    if (accept) begin
      crc_err_d = 1'b0;
    end
    if (frame_start) begin
      crc_d = 8'h00;
    end else if (rx_shift) begin
      // Last 8 bits in arrival order, first arrival in bit 7.
      tail_d = {tail_q[6:0], mosi_s2_q};
      if (frame_done) begin
        crc_d = 8'h00;
        if (deliver) begin
          crc_err_d = (tail_d != crc_q);
        end
      end else if (bit_cnt_q < CrcBits) begin
        crc_d = crc8_step(crc_q, mosi_s2_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q     <= 8'h00;
      tail_q    <= 8'h00;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      tail_q    <= tail_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign rx_crc_err = crc_err_q;
`else
  assign rx_crc_err = 1'b0;
`endif

  assign MCU_SPI_MISO = miso_q;
  assign miso_oe      = miso_oe_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame. Index 0 is a 64-bit mode-0, MSB-first slave.
// Indices 1..4 are 16-bit slaves:
//   1 = mode 1, MSB first
//   2 = mode 2, MSB first
//   3 = mode 3, MSB first
//   4 = mode 0, LSB first
// Delivered frames are checked against a scoreboard queue.
module tb_spi_slave_frame;

  localparam int HP = 8;  // SCK half period in CLK cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sck_p  [5];
  logic        mosi_p [5];
  logic        nss_p  [5];
  logic        rdy_p  [5];
  logic        miso_p [5];
  logic        oe_p   [5];
  logic        vld_p  [5];
  logic        ovr_p  [5];
  logic        ferr_p [5];
  logic        crc_p  [5];
  logic        busy_p [5];
  logic [63:0] tx0, rx0;
  logic [15:0] tx16 [1:4];
  logic [15:0] rx16 [1:4];

  spi_slave_frame #(
    .FRAME_BITS(64), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)
  ) u_dut0 (
    .CLK(clk), .RST(rst), .MCU_SPI_SCK(sck_p[0]), .MCU_SPI_MOSI(mosi_p[0]),
    .MCU_SPI_NSS(nss_p[0]), .MCU_SPI_MISO(miso_p[0]), .miso_oe(oe_p[0]),
    .tx_data(tx0), .rx_data(rx0), .rx_valid(vld_p[0]), .rx_ready(rdy_p[0]),
    .rx_overrun(ovr_p[0]), .frame_err(ferr_p[0]), .rx_crc_err(crc_p[0]), .busy(busy_p[0])
  );

  for (genvar g = 1; g < 5; g++) begin : g_dut16
    spi_slave_frame #(
      .FRAME_BITS(16), .CPOL(g == 2 || g == 3), .CPHA(g == 1 || g == 3), .MSB_FIRST(g != 4)
    ) u_dut (
      .CLK(clk), .RST(rst), .MCU_SPI_SCK(sck_p[g]), .MCU_SPI_MOSI(mosi_p[g]),
      .MCU_SPI_NSS(nss_p[g]), .MCU_SPI_MISO(miso_p[g]), .miso_oe(oe_p[g]),
      .tx_data(tx16[g]), .rx_data(rx16[g]), .rx_valid(vld_p[g]), .rx_ready(rdy_p[g]),
      .rx_overrun(ovr_p[g]), .frame_err(ferr_p[g]), .rx_crc_err(crc_p[g]), .busy(busy_p[g])
    );
  end

  function automatic logic cpol_of(input int d); return (d == 2 || d == 3); endfunction
  function automatic logic cpha_of(input int d); return (d == 1 || d == 3); endfunction
  function automatic logic msb_of(input int d);  return (d != 4);           endfunction
  function automatic int   nbits_of(input int d); return (d == 0) ? 64 : 16; endfunction

  function automatic logic [63:0] rxd(input int d);
    if (d == 0) return rx0;
    return 64'(rx16[d]);
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    int          d;
    logic [63:0] data;
    logic        crc;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input int d, input logic [63:0] data, input logic crc);
    exp_t e;
    e.d = d; e.data = data; e.crc = crc;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      for (int d = 0; d < 5; d++) begin
        if (vld_p[d] && rdy_p[d]) begin
          if (sb_q.size() == 0) begin
            check("unexpected_rx", rxd(d), 64'hx);
          end else begin
            e = sb_q.pop_front();
            check("rx_dut", 64'(d), 64'(e.d));
            check("rx_data", rxd(d), e.data);
            check("rx_crc_err", 64'(crc_p[d]), 64'(e.crc));
          end
        end
      end
    end
  end

  int ovr_cnt  = 0;
  int ferr_cnt = 0;
  always @(negedge clk) begin
    if (ovr_p[0])  ovr_cnt++;
    if (ferr_p[0]) ferr_cnt++;
  end

  // Table of 16-bit vectors
  typedef struct {
    int          d;
    logic [15:0] mosi;
    logic [15:0] tx;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
    logic        exp_crc;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int d, input logic [15:0] mosi, input logic [15:0] tx,
                         input logic [15:0] erx, input logic [15:0] emiso, input logic ecrc);
    vec_t v;
    v.d = d; v.mosi = mosi; v.tx = tx; v.exp_rx = erx; v.exp_miso = emiso; v.exp_crc = ecrc;
    vecs.push_back(v);
  endtask

  task automatic nss_set(input int d, input logic v);
    @(negedge clk);
    nss_p[d] = v;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic set_ready(input int d, input logic v);
    @(posedge clk);
    #1 rdy_p[d] = v;
  endtask

  // Master: clocks n bits of w, captures MISO on the mode's sample edge.
  task automatic spi_bits(input int d, input int n, input logic [63:0] w,
                          output logic [63:0] cap);
    int   nb;
    int   idx;
    logic cpol, cpha;
    nb   = nbits_of(d);
    cpol = cpol_of(d);
    cpha = cpha_of(d);
    cap  = '0;
    for (int i = 0; i < n; i++) begin
      idx = msb_of(d) ? (nb - 1 - i) : i;
      if (!cpha) mosi_p[d] = w[idx];
      repeat (HP) @(negedge clk);
      sck_p[d] = ~cpol;
      if (!cpha) cap[idx] = miso_p[d];
      else       mosi_p[d] = w[idx];
      repeat (HP) @(negedge clk);
      sck_p[d] = cpol;
      if (cpha) cap[idx] = miso_p[d];
    end
    repeat (HP) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [63:0] cap;
    int          base;

    add_vec(1, 16'hA55A, 16'h3C96, 16'hA55A, 16'h3C96, 1'b0);
    add_vec(2, 16'hA55A, 16'h1234, 16'hA55A, 16'h1234, 1'b0);
    add_vec(3, 16'hA55A, 16'hF00F, 16'hA55A, 16'hF00F, 1'b0);
    add_vec(4, 16'hA55A, 16'h8001, 16'hA55A, 16'h8001, 1'b0);
`ifdef SPI_SLAVE_FRAME_CRC8_EN
    add_vec(1, 16'h0107, 16'h0000, 16'h0107, 16'h0000, 1'b0);
    add_vec(1, 16'h0108, 16'h0000, 16'h0108, 16'h0000, 1'b1);
`endif

    rst = 1'b1;
    tx0 = '0;
    for (int d = 0; d < 5; d++) begin
      sck_p[d] = cpol_of(d); mosi_p[d] = 1'b0; nss_p[d] = 1'b1; rdy_p[d] = 1'b1;
    end
    for (int d = 1; d < 5; d++) tx16[d] = '0;

    repeat (4) @(negedge clk);
    check("reset_miso",    64'(miso_p[0]), 64'd0);
    check("reset_miso_oe", 64'(oe_p[0]),   64'd0);
    check("reset_rx_data", rx0,            64'd0);
    check("reset_rx_vld",  64'(vld_p[0]),  64'd0);
    check("reset_busy",    64'(busy_p[0]), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Full 64-bit mode-0 frame
    tx0 = 64'hDEAD_BEEF_CAFE_F00D;
    push_exp(0, 64'h0123_4567_89AB_CDEF, 1'b0);
    nss_set(0, 1'b0);
    check("t1_busy", 64'(busy_p[0]), 64'd1);
    check("t1_oe",   64'(oe_p[0]),   64'd1);
    spi_bits(0, 64, 64'h0123_4567_89AB_CDEF, cap);
    nss_set(0, 1'b1);
    check("t1_miso", cap, 64'hDEAD_BEEF_CAFE_F00D);
    check("t1_idle_busy", 64'(busy_p[0]), 64'd0);
    check("t1_idle_oe",   64'(oe_p[0]),   64'd0);
    check("t1_drained",   64'(sb_q.size()), 64'd0);

    // Mode / bit-order table
    for (int k = 0; k < vecs.size(); k++) begin
      tx16[vecs[k].d] = vecs[k].tx;
      push_exp(vecs[k].d, 64'(vecs[k].exp_rx), vecs[k].exp_crc);
      nss_set(vecs[k].d, 1'b0);
      spi_bits(vecs[k].d, 16, 64'(vecs[k].mosi), cap);
      nss_set(vecs[k].d, 1'b1);
      check("t2_miso", cap, 64'(vecs[k].exp_miso));
      check("t2_drained", 64'(sb_q.size()), 64'd0);
    end

    // Short frame: NSS rises after 20 bits
    base = ferr_cnt;
    nss_set(0, 1'b0);
    spi_bits(0, 20, 64'hFFFF_FFFF_FFFF_FFFF, cap);
    nss_set(0, 1'b1);
    check("t3_ferr_cycles", 64'(ferr_cnt - base), 64'd1);
    check("t3_rx_vld", 64'(vld_p[0]), 64'd0);
    push_exp(0, 64'h5555_AAAA_1234_8765, 1'b0);
    nss_set(0, 1'b0);
    spi_bits(0, 64, 64'h5555_AAAA_1234_8765, cap);
    nss_set(0, 1'b1);
    check("t3_drained", 64'(sb_q.size()), 64'd0);
    check("t3_ferr_after", 64'(ferr_cnt - base), 64'd1);

    // Overrun: two back-to-back frames with rx_ready low
    base = ovr_cnt;
    set_ready(0, 1'b0);
    push_exp(0, 64'h1, 1'b0);
    nss_set(0, 1'b0);
    spi_bits(0, 64, 64'h1, cap);
    spi_bits(0, 64, 64'h2, cap);
    nss_set(0, 1'b1);
    check("t4_rx_hold", rx0, 64'h1);
    check("t4_vld_held", 64'(vld_p[0]), 64'd1);
    check("t4_overrun_cycles", 64'(ovr_cnt - base), 64'd1);
    set_ready(0, 1'b1);
    @(negedge clk);
    check("t4_vld_at_accept", 64'(vld_p[0]), 64'd1);
    @(negedge clk);
    check("t4_vld_cleared", 64'(vld_p[0]), 64'd0);
    check("t4_drained", 64'(sb_q.size()), 64'd0);

    // Reset mid-frame with NSS held low
    base = ferr_cnt;
    nss_set(0, 1'b0);
    spi_bits(0, 10, 64'hAAAA_AAAA_AAAA_AAAA, cap);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    spi_bits(0, 64, 64'h1357_9BDF_2468_ACE0, cap);
    check("t5_no_rx", 64'(vld_p[0]), 64'd0);
    check("t5_not_busy", 64'(busy_p[0]), 64'd0);
    check("t5_no_ferr", 64'(ferr_cnt - base), 64'd0);
    nss_set(0, 1'b1);
    push_exp(0, 64'hFFFF_0000_FFFF_0000, 1'b0);
    nss_set(0, 1'b0);
    spi_bits(0, 64, 64'hFFFF_0000_FFFF_0000, cap);
    nss_set(0, 1'b1);
    check("t5_drained", 64'(sb_q.size()), 64'd0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
